riscv_soft_unified_mem: RTL and testbench

Parametrised unified on-chip memory for the riscv-soft core. It provides one dedicated instruction-fetch read port and `NUM_PORTS` arbitrated load/store ports; port 0 is the host port and ports 1 and up are core data ports. It adds byte and halfword access with byte enables and sign extension, misalignment and range error reporting, and selectable arbitration. It sits between the core/host request buses and a single inferred word RAM.

---
 rtl/riscv_soft_mem_pkg.sv | 46 ++++
 rtl/riscv_soft_unified_mem_if.sv | 33 +++
 rtl/riscv_soft_mem_arbiter.sv | 61 ++++++
 rtl/riscv_soft_unified_mem.sv | 136 +++++++++++++
 tb/tb_riscv_soft_unified_mem.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_soft_mem_pkg.sv
// Shared definitions for the riscv-soft unified memory: op codes, access sizes,
// and the byte-enable, store-lane and load-extract helpers.
package riscv_soft_mem_pkg;

    localparam logic [1:0] MEM_LOAD  = 2'd0;
    localparam logic [1:0] MEM_STORE = 2'd1;

    localparam logic [2:0] MEM_TYPE_B  = 3'd0;
    localparam logic [2:0] MEM_TYPE_H  = 3'd1;
    localparam logic [2:0] MEM_TYPE_W  = 3'd2;
    localparam logic [2:0] MEM_TYPE_BU = 3'd4;
    localparam logic [2:0] MEM_TYPE_HU = 3'd5;

    function automatic logic [3:0] byte_enable(input logic [2:0] op_type, input logic [1:0] offset);
        case (op_type)
            MEM_TYPE_B, MEM_TYPE_BU: byte_enable = 4'b0001 << offset;
            MEM_TYPE_H, MEM_TYPE_HU: byte_enable = 4'b0011 << offset;
            default:                 byte_enable = 4'b1111;
        endcase
    endfunction

    // Narrow store data is copied to every lane so the byte enables alone pick the target.
    function automatic logic [31:0] store_lanes(input logic [2:0] op_type, input logic [31:0] data);
        case (op_type)
            MEM_TYPE_B, MEM_TYPE_BU: store_lanes = {4{data[7:0]}};
            MEM_TYPE_H, MEM_TYPE_HU: store_lanes = {2{data[15:0]}};
            default:                 store_lanes = data;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] op_type,
                                                 input logic [1:0] offset);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{offset, 3'b000} +: 8];
        h = offset[1] ? word[31:16] : word[15:0];
        case (op_type)
            MEM_TYPE_B:  load_extract = {{24{b[7]}}, b};
            MEM_TYPE_BU: load_extract = {24'd0, b};
            MEM_TYPE_H:  load_extract = {{16{h[15]}}, h};
            MEM_TYPE_HU: load_extract = {16'd0, h};
            default:     load_extract = word;
        endcase
    endfunction

endpackage

// File: rtl/riscv_soft_unified_mem_if.sv
// Request/response bus of the unified memory: one fetch read port plus
// NUM_PORTS packed load/store requesters sharing one response data bus.
interface riscv_soft_unified_mem_if #(
    parameter int NUM_PORTS = 2,
    parameter int XPR_LEN   = 32
);
    logic                           i_fetch_req_valid;
    logic                           i_fetch_req_ready;
    logic [XPR_LEN-1:0]             i_fetch_req_addr;
    logic                           i_fetch_resp_valid;
    logic [XPR_LEN-1:0]             i_fetch_resp_data;
    logic [NUM_PORTS-1:0]           req_valid;
    logic [NUM_PORTS-1:0]           req_ready;
    logic [2*NUM_PORTS-1:0]         req_op;
    logic [3*NUM_PORTS-1:0]         req_op_type;
    logic [XPR_LEN*NUM_PORTS-1:0]   req_addr;
    logic [XPR_LEN*NUM_PORTS-1:0]   req_data;
    logic [NUM_PORTS-1:0]           resp_valid;
    logic [XPR_LEN-1:0]             resp_data;
    logic                           resp_err;

    modport master (
        output i_fetch_req_valid, i_fetch_req_addr, req_valid, req_op, req_op_type, req_addr, req_data,
        input  i_fetch_req_ready, i_fetch_resp_valid, i_fetch_resp_data, req_ready, resp_valid,
               resp_data, resp_err
    );

    modport slave (
        input  i_fetch_req_valid, i_fetch_req_addr, req_valid, req_op, req_op_type, req_addr, req_data,
        output i_fetch_req_ready, i_fetch_resp_valid, i_fetch_resp_data, req_ready, resp_valid,
               resp_data, resp_err
    );
endinterface

// File: rtl/riscv_soft_mem_arbiter.sv
// Request vector to one-hot grant. RISCV_SOFT_MEM_RR_ARB_EN selects round-robin;
// otherwise fixed priority with the lowest index (host) winning.
module riscv_soft_mem_arbiter #(
    parameter int NUM_PORTS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req_valid,
    output logic [NUM_PORTS-1:0] grant
);
`ifdef RISCV_SOFT_MEM_RR_ARB_EN
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] next_ptr;

    always_comb begin
        logic          found;
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_PORTS))
                sum = sum - (PW+1)'(NUM_PORTS);
            idx = sum[PW-1:0];
            if (req_valid[idx] && !found) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                next_ptr   = (32'(idx) + 1 == NUM_PORTS) ? '0 : idx + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (|grant)
            ptr <= next_ptr;
    end
`else
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (req_valid[i] && !found) begin
                found    = 1'b1;
                grant[i] = 1'b1;
            end
        end
    end

    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
`endif
endmodule

// File: rtl/riscv_soft_unified_mem.sv
// Unified word RAM with a free-running fetch port and arbitrated B/H/W load/store ports.
// Arbitration policy is chosen by RISCV_SOFT_MEM_RR_ARB_EN (see riscv_soft_mem_arbiter).
module riscv_soft_unified_mem
    import riscv_soft_mem_pkg::*;
#(
    parameter int DEPTH     = 512,
    parameter int XPR_LEN   = 32,
    parameter int NUM_PORTS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    riscv_soft_unified_mem_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [XPR_LEN-1:0]   mem [DEPTH];
    logic [NUM_PORTS-1:0] grant;

    riscv_soft_mem_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arbiter (
        .clk       (clk),
        .reset     (reset),
        .req_valid (bus.req_valid),
        .grant     (grant)
    );

    assign bus.req_ready         = grant & {NUM_PORTS{~reset}};
    assign bus.i_fetch_req_ready = 1'b1;

    logic [1:0]         sel_op;
    logic [2:0]         sel_type;
    logic [XPR_LEN-1:0] sel_addr;
    logic [XPR_LEN-1:0] sel_data;

    always_comb begin
        sel_op   = '0;
        sel_type = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                sel_op   = bus.req_op[2*i +: 2];
                sel_type = bus.req_op_type[3*i +: 3];
                sel_addr = bus.req_addr[XPR_LEN*i +: XPR_LEN];
                sel_data = bus.req_data[XPR_LEN*i +: XPR_LEN];
            end
        end
    end

    logic          accept;
    logic          is_store;
    logic          misaligned;
    logic          range_err;
    logic          acc_err;
    logic          wr_en;
    logic [1:0]    offset;
    logic [AW-1:0] widx;
    logic [3:0]    be;
    logic [31:0]   wdata;

    assign accept    = |bus.req_ready;
    assign is_store  = (sel_op == MEM_STORE);
    assign offset    = sel_addr[1:0];
    assign widx      = sel_addr[AW+1:2];
    assign range_err = |sel_addr[XPR_LEN-1:AW+2];

    always_comb begin
        case (sel_type)
            MEM_TYPE_B, MEM_TYPE_BU: misaligned = 1'b0;
            MEM_TYPE_H, MEM_TYPE_HU: misaligned = offset[0];
            MEM_TYPE_W:              misaligned = (offset != 2'd0);
            default:                 misaligned = 1'b1;
        endcase
    end

    assign acc_err = misaligned | range_err;
    assign wr_en   = accept & is_store & ~acc_err;
    assign be      = byte_enable(sel_type, offset);
    assign wdata   = store_lanes(sel_type, sel_data);

    // Masked per-byte write; load port reads the pre-write word, which never collides
    // because only one load/store is accepted per cycle.
    logic [31:0] ld_word;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (be[b])
                    mem[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
        if (accept)
            ld_word <= mem[widx];
    end

    logic [AW-1:0]        fidx;
    logic [NUM_PORTS-1:0] resp_valid_q;
    logic                 resp_err_q;
    logic                 load_q;
    logic [2:0]           type_q;
    logic [1:0]           offset_q;
    logic                 fetch_valid_q;
    logic [XPR_LEN-1:0]   fetch_data_q;

    assign fidx = bus.i_fetch_req_addr[AW+1:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid_q  <= '0;
            resp_err_q    <= 1'b0;
            load_q        <= 1'b0;
            type_q        <= '0;
            offset_q      <= '0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
        end else begin
            resp_valid_q  <= bus.req_ready;
            resp_err_q    <= accept & acc_err;
            load_q        <= accept & ~is_store & ~acc_err;
            if (accept) begin
                type_q   <= sel_type;
                offset_q <= offset;
            end
            fetch_valid_q <= bus.i_fetch_req_valid;
            if (bus.i_fetch_req_valid)
                fetch_data_q <= mem[fidx];
        end
    end

    assign bus.resp_valid         = resp_valid_q;
    assign bus.resp_err           = resp_err_q;
    assign bus.resp_data          = load_q ? load_extract(ld_word, type_q, offset_q) : '0;
    assign bus.i_fetch_resp_valid = fetch_valid_q;
    assign bus.i_fetch_resp_data  = fetch_data_q;

    logic unused_fetch_bits;
    assign unused_fetch_bits = ^{bus.i_fetch_req_addr[XPR_LEN-1:AW+2], bus.i_fetch_req_addr[1:0]};
endmodule

// File: tb/tb_riscv_soft_unified_mem.sv
// Scoreboard bench for riscv_soft_unified_mem against a byte-addressed memory model.
module tb_riscv_soft_unified_mem;
    import riscv_soft_mem_pkg::*;

    localparam int DEPTH = 64;
    localparam int NP    = 2;
    localparam int XL    = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    riscv_soft_unified_mem_if #(.NUM_PORTS(NP), .XPR_LEN(XL)) bus();

    riscv_soft_unified_mem #(.DEPTH(DEPTH), .XPR_LEN(XL), .NUM_PORTS(NP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int port; logic err; logic [31:0] data; int cyc; } exp_t;
    typedef struct { logic [31:0] data; int cyc; } fexp_t;
    exp_t  sbq[$];
    fexp_t fq[$];

    logic [7:0]  mem_b [4*DEPTH];
    logic        pv  [NP];
    logic [1:0]  pop [NP];
    logic [2:0]  pty [NP];
    logic [31:0] pa  [NP];
    logic [31:0] pd  [NP];
    logic        fv = 1'b0;
    logic [31:0] fa = '0;
    int          rr_ptr = 0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void flag(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endfunction

    // Behavioural model: byte-addressed memory, access size from funct3.
    function automatic void model(input logic [1:0] op, input logic [2:0] ty, input logic [31:0] a,
                                  input logic [31:0] d, output logic err, output logic [31:0] r);
        int nb;
        r  = '0;
        nb = (ty == 3'd0 || ty == 3'd4) ? 1 : (ty == 3'd1 || ty == 3'd5) ? 2 : 4;
        err = (a >= 32'(4*DEPTH)) || ty == 3'd3 || ty == 3'd6 || ty == 3'd7 || (a % 32'(nb) != 0);
        if (err) return;
        if (op == MEM_STORE) begin
            for (int k = 0; k < nb; k++) mem_b[int'(a) + k] = d[8*k +: 8];
        end else begin
            for (int k = 0; k < nb; k++) r[8*k +: 8] = mem_b[int'(a) + k];
            if ((ty == 3'd0 || ty == 3'd1) && r[8*nb-1])
                for (int k = nb; k < 4; k++) r[8*k +: 8] = 8'hFF;
        end
    endfunction

    function automatic logic [31:0] fetch_word(input logic [31:0] a);
        int w;
        w = int'((a >> 2) % 32'(DEPTH));
        return {mem_b[4*w+3], mem_b[4*w+2], mem_b[4*w+1], mem_b[4*w]};
    endfunction

    task automatic step();
        logic [NP-1:0] exp_g;
        logic          err;
        logic [31:0]   r;
        int            g;
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            bus.req_valid[p]             = pv[p];
            bus.req_op[2*p +: 2]         = pop[p];
            bus.req_op_type[3*p +: 3]    = pty[p];
            bus.req_addr[XL*p +: XL]     = pa[p];
            bus.req_data[XL*p +: XL]     = pd[p];
        end
        bus.i_fetch_req_valid = fv;
        bus.i_fetch_req_addr  = fa;
        #1;
        g = -1;
        for (int k = 0; k < NP; k++)
            if (g < 0 && pv[(rr_ptr + k) % NP]) g = (rr_ptr + k) % NP;
        exp_g = (g >= 0) ? (NP'(1) << g) : '0;
        check("grant", 32'(bus.req_ready), 32'(exp_g));
        if (fv) begin
            check("fetch_ready", 32'(bus.i_fetch_req_ready), 32'd1);
            fq.push_back('{fetch_word(fa), cyc});
        end
        if (g >= 0) begin
            model(pop[g], pty[g], pa[g], pd[g], err, r);
            sbq.push_back('{g, err, r, cyc});
            pv[g] = 1'b0;
`ifdef RISCV_SOFT_MEM_RR_ARB_EN
            rr_ptr = (g + 1) % NP;
`endif
        end
        fv = 1'b0;
    endtask

    task automatic issue(input int p, input logic [1:0] op, input logic [2:0] ty,
                         input logic [31:0] a, input logic [31:0] d);
        pv[p] = 1'b1; pop[p] = op; pty[p] = ty; pa[p] = a; pd[p] = d;
        for (int n = 0; n < 20 && pv[p]; n++) step();
        if (pv[p]) begin
            flag("issue_timeout");
            pv[p] = 1'b0;
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    initial begin
        exp_t  e;
        fexp_t f;
        forever begin
            @(posedge clk);
            #2;
            if (reset) continue;
            if (bus.resp_valid != '0) begin
                if (sbq.size() == 0) flag("unexpected_resp");
                else begin
                    e = sbq.pop_front();
                    check("resp_port", 32'(bus.resp_valid), 32'(NP'(1) << e.port));
                    check("resp_err", 32'(bus.resp_err), 32'(e.err));
                    check("resp_data", bus.resp_data, e.data);
                end
            end else if (sbq.size() > 0 && sbq[0].cyc + 1 <= cyc) begin
                flag("missing_resp");
                void'(sbq.pop_front());
            end
            if (bus.i_fetch_resp_valid) begin
                if (fq.size() == 0) flag("unexpected_fetch");
                else begin
                    f = fq.pop_front();
                    check("fetch_data", bus.i_fetch_resp_data, f.data);
                end
            end else if (fq.size() > 0 && fq[0].cyc + 1 <= cyc) begin
                flag("missing_fetch");
                void'(fq.pop_front());
            end
        end
    end

    initial begin
        logic [2:0] tys [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [2:0] ty;
        logic [31:0] a;
        for (int p = 0; p < NP; p++) begin
            pv[p] = 1'b0; pop[p] = '0; pty[p] = '0; pa[p] = '0; pd[p] = '0;
        end
        bus.req_valid = '0; bus.req_op = '0; bus.req_op_type = '0;
        bus.req_addr = '0; bus.req_data = '0;
        bus.i_fetch_req_valid = 1'b0; bus.i_fetch_req_addr = '0;

        repeat (2) @(negedge clk);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_data", bus.resp_data, 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_fetch_valid", 32'(bus.i_fetch_resp_valid), 32'd0);
        check("rst_fetch_data", bus.i_fetch_resp_data, 32'd0);
        reset = 1'b0;

        for (int w = 0; w < DEPTH; w++) issue(0, MEM_STORE, MEM_TYPE_W, 32'(4*w), $urandom());

        issue(1, MEM_STORE, MEM_TYPE_W, 32'h10, 32'hDEADBEEF);
        issue(1, MEM_LOAD, MEM_TYPE_B, 32'h13, 32'h0);
        issue(1, MEM_LOAD, MEM_TYPE_BU, 32'h13, 32'h0);
        issue(1, MEM_LOAD, MEM_TYPE_HU, 32'h12, 32'h0);
        issue(1, MEM_STORE, MEM_TYPE_B, 32'h11, 32'h5A);
        issue(1, MEM_LOAD, MEM_TYPE_W, 32'h10, 32'h0);
        issue(1, MEM_STORE, MEM_TYPE_H, 32'h21, 32'h1234);
        issue(1, MEM_STORE, MEM_TYPE_W, 32'h22, 32'h5555AAAA);
        issue(1, MEM_STORE, MEM_TYPE_W, 32'(4*DEPTH), 32'h77777777);
        issue(1, MEM_LOAD, MEM_TYPE_H, 32'h21, 32'h0);
        issue(1, MEM_LOAD, MEM_TYPE_W, 32'h22, 32'h0);
        issue(1, MEM_LOAD, 3'd3, 32'h20, 32'h0);
        issue(1, MEM_LOAD, MEM_TYPE_W, 32'h20, 32'h0);
        issue(1, MEM_LOAD, MEM_TYPE_W, 32'h0, 32'h0);

        // Both ports continuously valid for four cycles.
        for (int n = 0; n < 4; n++) begin
            for (int p = 0; p < NP; p++)
                if (!pv[p]) begin
                    pv[p] = 1'b1; pop[p] = MEM_LOAD; pty[p] = MEM_TYPE_W; pa[p] = 32'(8*n + 4*p); pd[p] = '0;
                end
            step();
        end
        for (int n = 0; n < 4 && (pv[0] || pv[1]); n++) step();

        // Fetch racing a store to the same word, then refetch.
        fv = 1'b1; fa = 32'h10;
        issue(1, MEM_STORE, MEM_TYPE_W, 32'h10, 32'hCAFEF00D);
        fv = 1'b1; fa = 32'h10;
        step();

        // Reset in the cycle after a grant drops the pending response.
        fv = 1'b1; fa = 32'h4;
        pv[1] = 1'b1; pop[1] = MEM_LOAD; pty[1] = MEM_TYPE_W; pa[1] = 32'h10; pd[1] = '0;
        step();
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst_drop_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_drop_fetch_valid", 32'(bus.i_fetch_resp_valid), 32'd0);
        sbq.delete();
        fq.delete();
        rr_ptr = 0;
        @(negedge clk);
        bus.req_valid = '0;
        bus.i_fetch_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) step();
        // Pointer restarts at 0 after reset.
        issue(1, MEM_LOAD, MEM_TYPE_W, 32'h14, 32'h0);
        pv[0] = 1'b1; pop[0] = MEM_LOAD; pty[0] = MEM_TYPE_W; pa[0] = 32'h18; pd[0] = '0;
        pv[1] = 1'b1; pop[1] = MEM_LOAD; pty[1] = MEM_TYPE_W; pa[1] = 32'h1C; pd[1] = '0;
        for (int n = 0; n < 4 && (pv[0] || pv[1]); n++) step();

        for (int n = 0; n < 1200; n++) begin
            for (int p = 0; p < NP; p++) begin
                if (!pv[p] && $urandom_range(0, 9) < 6) begin
                    ty = ($urandom_range(0, 9) == 0) ? 3'(3 + 3 * $urandom_range(0, 1) + $urandom_range(0, 1))
                                                     : tys[$urandom_range(0, 4)];
                    a = 32'($urandom_range(0, 4*DEPTH + 31));
                    if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
                    pv[p] = 1'b1;
                    pop[p] = ($urandom_range(0, 9) < 4) ? MEM_STORE : MEM_LOAD;
                    pty[p] = ty; pa[p] = a; pd[p] = $urandom();
                end
            end
            fv = ($urandom_range(0, 1) == 1);
            fa = $urandom();
            step();
        end
        for (int n = 0; n < 10 && (pv[0] || pv[1]); n++) step();
        repeat (3) step();
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        check("fetch_queue_empty", 32'(fq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
